// File: rtl/i2c_target_regs.sv
// I2C target with a register-file back end: synchronised pins, repeated START,
// pointer auto-increment with wrap, burst read/write and out-of-range NACK.
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h70,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] rd_addr_o,
    input  logic [7:0] rd_data_i,
    output logic       wr_en_o,
    output logic [7:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    output logic       busy_o,
    output logic [3:0] dbg_state_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT_STOP
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic [3:0]             r_bitcnt;
    logic [6:0]             r_shift;
    logic [6:0]             r_tx;
    logic [7:0]             r_ptr;
    logic                   r_rw;
    logic                   r_sda_oe;
    logic                   r_wr_en;
    logic [7:0]             r_wr_addr;
    logic [7:0]             r_wr_data;
    logic                   r_busy;

    logic       w_scl;
    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_byte;
    logic       w_last_bit;
    logic [7:0] w_ptr_next;

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    // SCL must be high in both samples, so a simultaneous SCL change wins
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_byte     = {r_shift, w_sda};
    assign w_last_bit = w_scl_rise && (r_bitcnt == 4'd7);
    assign w_ptr_next = (r_ptr == 8'(NUM_REGS - 1)) ? 8'd0 : r_ptr + 8'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
            r_bitcnt   <= 4'd0;
            r_shift    <= 7'd0;
            r_tx       <= 7'd0;
            r_ptr      <= 8'd0;
            r_rw       <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= 8'd0;
            r_wr_data  <= 8'd0;
            r_busy     <= 1'b0;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
            r_wr_en    <= 1'b0;
            if (w_start) begin
                r_state  <= S_ADDR;
                r_bitcnt <= 4'd0;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else if (w_stop) begin
                r_state  <= S_IDLE;
                r_bitcnt <= 4'd0;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR, S_PTR, S_WDATA: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte[6:0];
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                        if (w_last_bit) begin
                            r_bitcnt <= 4'd0;
                            if (r_state == S_ADDR) begin
                                if (w_byte[7:1] == TARGET_ADDR) begin
                                    r_state <= S_ADDR_ACK;
                                    r_busy  <= 1'b1;
                                    r_rw    <= w_byte[0];
                                end else begin
                                    r_state <= S_WAIT_STOP;
                                    r_busy  <= 1'b0;
                                end
                            end else if (r_state == S_PTR) begin
                                if ({1'b0, w_byte} < 9'(NUM_REGS)) begin
                                    r_ptr   <= w_byte;
                                    r_state <= S_PTR_ACK;
                                end else begin
                                    r_state <= S_WAIT_STOP;
                                end
                            end else begin
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= r_ptr;
                                r_wr_data <= w_byte;
                                r_ptr     <= w_ptr_next;
                                r_state   <= S_WDATA_ACK;
                            end
                        end
                    end
                    // first fall drives ACK, second fall ends the ACK bit
                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                        if (w_scl_fall) begin
                            if (r_bitcnt == 4'd0) begin
                                r_sda_oe <= 1'b1;
                                r_bitcnt <= 4'd1;
                            end else begin
                                r_bitcnt <= 4'd0;
                                r_sda_oe <= 1'b0;
                                if (r_state == S_ADDR_ACK && r_rw) begin
                                    r_state  <= S_RDATA;
                                    r_sda_oe <= ~rd_data_i[7];
                                    r_tx     <= rd_data_i[6:0];
                                end else if (r_state == S_ADDR_ACK) begin
                                    r_state <= S_PTR;
                                end else begin
                                    r_state <= S_WDATA;
                                end
                            end
                        end
                    end
                    S_RDATA: begin
                        if (w_scl_rise) begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (r_bitcnt == 4'd7)
                                r_ptr <= w_ptr_next;
                        end else if (w_scl_fall) begin
                            if (r_bitcnt == 4'd8) begin
                                r_state  <= S_RDATA_ACK;
                                r_sda_oe <= 1'b0;
                                r_bitcnt <= 4'd0;
                            end else begin
                                r_sda_oe <= ~r_tx[6];
                                r_tx     <= {r_tx[5:0], 1'b0};
                            end
                        end
                    end
                    S_RDATA_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda)
                                r_state <= S_WAIT_STOP;
                            else
                                r_bitcnt <= 4'd1;
                        end else if (w_scl_fall && r_bitcnt == 4'd1) begin
                            r_state  <= S_RDATA;
                            r_bitcnt <= 4'd0;
                            r_sda_oe <= ~rd_data_i[7];
                            r_tx     <= rd_data_i[6:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe_o    = r_sda_oe;
    assign rd_addr_o   = r_ptr;
    assign wr_en_o     = r_wr_en;
    assign wr_addr_o   = r_wr_addr;
    assign wr_data_o   = r_wr_data;
    assign busy_o      = r_busy;
    assign dbg_state_o = r_state;

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

Parametrised I2C target with a register-file back end: the successor to the single-byte, fixed-behaviour target. Adds input synchronisers, open-drain output split, repeated-START support, configurable register count, multi-byte burst writes/reads with pointer auto-increment, and NACK of out-of-range pointers. Sits between the board I2C pins and the PWM register bank; the register storage lives outside this block.

## Interface

Parameters:
- TARGET_ADDR, 7'h70, 7-bit address this target responds to
- NUM_REGS, 16, number of addressable registers (1..256)
- SYNC_STAGES, 2, flops in each SCL/SDA input synchroniser (>=2)

Ports:
- clk_i  input  1  system clock; the only clock in the block
- rst_i  input  1  reset, synchronous, active-high
- scl_i  input  1  raw I2C SCL pin
- sda_i  input  1  raw I2C SDA pin (read back)
- sda_oe_o  output  1  1 = pull SDA low; 0 = release (pad is open-drain)
- rd_addr_o  output  8  register index being read (= pointer)
- rd_data_i  input  8  register contents at rd_addr_o, combinational from bank
- wr_en_o  output  1  one-cycle write strobe
- wr_addr_o  output  8  write register index, valid with wr_en_o
- wr_data_o  output  8  write data, valid with wr_en_o
- busy_o  output  1  1 from address match until STOP/START
- dbg_state_o  output  4  current FSM state encoding

## Operation

- SCL/SDA pass through SYNC_STAGES flops; all edges detected on synced copies versus one further delayed copy.
- START: synced SDA falls while synced SCL high. STOP: SDA rises while SCL high. Both recognised in every state (repeated START included) and abort any byte in progress; START -> ADDR with bit count 0, STOP -> IDLE. SCL and SDA changing in the same sampled cycle: treated as SCL edge only.
- Data sampled on SCL rise; sda_oe_o updated only on SCL fall.
- States (encoding 0..9): IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- ADDR: shift 8 bits MSB first (7 address + R/W). Match -> ADDR_ACK (drive 0); mismatch -> WAIT_STOP, SDA never driven.
- After ADDR_ACK: W -> PTR; R -> RDATA with first byte loaded from rd_data_i at current pointer.
- PTR: 8 bits. Value < NUM_REGS -> load pointer, PTR_ACK, then WDATA. Value >= NUM_REGS -> NACK (release), WAIT_STOP, pointer unchanged.
- WDATA: 8 bits, then wr_en_o pulse with wr_addr_o = pointer, wr_data_o = byte, ACK, pointer increments, WDATA again. Unlimited burst.
- RDATA: shift byte out MSB first (bit 0 -> drive, bit 1 -> release). Pointer increments after bit 8. RDATA_ACK releases SDA and samples controller: ACK (0) -> load next byte from rd_data_i, RDATA; NACK (1) -> WAIT_STOP.
- Pointer wraps NUM_REGS-1 -> 0 on increment, for both read and write. Pointer persists across transactions (write pointer, repeated START, read works); reset only by rst_i.
- WAIT_STOP: SDA released, ignore everything except START/STOP.

## Timing

- Reset values: sda_oe_o 0, wr_en_o 0, wr_addr_o 0, wr_data_o 0, rd_addr_o 0, busy_o 0, dbg_state_o 0 (IDLE), pointer 0, bit count 0. rst_i mid-transaction releases SDA on the next clk.
- Pin-to-effect latency: SYNC_STAGES+1 clk from raw pin edge to edge detection; sda_oe_o changes on the following clk.
- clk_i must be >= 16x SCL frequency; data setup on SDA is then met with margin.
- wr_en_o asserts exactly one clk, on the cycle after detection of the 8th data-bit SCL rise; one pulse per byte.
- rd_data_i sampled on the clk where the SCL fall ending ADDR_ACK or RDATA_ACK is detected; rd_addr_o stable from that pointer update until then.
- busy_o clears on the cycle STOP/START is detected or on ADDR mismatch.

## Test plan

- Write 0x70 W, ptr 0x03, data 0xA5 0x5A, STOP -> ACK on all 4 bytes; wr_en_o pulses (3,0xA5), (4,0x5A); final state IDLE.
- Write ptr 0x02, repeated START, 0x70 R, read 3 bytes ACK,ACK,NACK with bank = index*0x11 -> SDA bytes 0x22,0x33,0x44; WAIT_STOP after NACK.
- NUM_REGS=16, write burst from ptr 0x0F of 2 bytes -> writes at 15 then 0 (wrap); ptr 0x10 -> NACK, no wr_en_o, WAIT_STOP.
- Address 0x71 -> sda_oe_o never asserts, busy_o stays 0, then START + 0x70 accepted normally.
- START mid-data byte (after 4 bits) -> no write, ADDR restarts; rst_i asserted during ADDR_ACK -> sda_oe_o 0 next clk, pointer 0.
- Raw SDA glitch of 1 clk with SCL high, SYNC_STAGES=2 -> at most one START/STOP pair, SDA released, no spurious write.
